// File: rtl/vend_controller_pkg.sv
// Shared definitions for the vending machine controller: FSM state encoding,
// coin codes and the coin-code to credit-unit decode.
package vend_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CREDIT   = 3'd1,
    ST_COMPARE  = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4
  } state_t;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  localparam logic [3:0] COIN_1_VAL  = 4'd1;
  localparam logic [3:0] COIN_2_VAL  = 4'd2;
  localparam logic [3:0] COIN_5_VAL  = 4'd5;
  localparam logic [3:0] COIN_10_VAL = 4'd10;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return COIN_1_VAL;
      COIN_2:  return COIN_2_VAL;
      COIN_5:  return COIN_5_VAL;
      default: return COIN_10_VAL;
    endcase
  endfunction

endpackage

// File: rtl/vend_controller_subtractor.sv
// 4-bit subtractor shared by the price check and the change return.
// bout_o is high when a >= b (no borrow out of the top bit).
module parallel_subtractor (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] diff_o,
  output logic       bout_o
);

  logic [4:0] wide_d;

  assign wide_d = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o = wide_d[3:0];
  assign bout_o = ~wide_d[4];

endmodule

// File: rtl/vend_controller.sv
// Vending controller: accumulates coin credit, checks selections against price
// through one shared subtractor, pulses dispense and returns change unit by unit.
module vend_controller
  import vend_controller_pkg::*;
#(
  parameter logic [3:0] PRICE_A = 4'd5,
  parameter logic [3:0] PRICE_B = 4'd7,
  parameter logic [3:0] PRICE_C = 4'd10,
  parameter logic [3:0] PRICE_D = 4'd12,
  parameter int         TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  output logic [3:0] credit,
  output logic       busy,
  output logic       dispense,
  output logic [1:0] dispense_item,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       err_insufficient,
  output state_t     state_dbg
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q;
  logic [3:0]    credit_q;
  logic [1:0]    item_q;
  logic [3:0]    price_q;
  logic [TW-1:0] tmo_q;
  logic          coin_reject_q;
  logic          err_q;

  logic [4:0] coin_sum_d;
  logic       coin_fits_d;
  logic [3:0] sel_price_d;
  logic [3:0] sub_b_d;
  logic [3:0] sub_diff_d;
  logic       sub_bout_d;

  assign coin_sum_d  = {1'b0, credit_q} + {1'b0, coin_value(coin_val)};
  assign coin_fits_d = ~coin_sum_d[4];

  always_comb begin
    sel_price_d = PRICE_A;
    case (sel)
      2'd0:    sel_price_d = PRICE_A;
      2'd1:    sel_price_d = PRICE_B;
      2'd2:    sel_price_d = PRICE_C;
      default: sel_price_d = PRICE_D;
    endcase
  end

  // Price only feeds the subtractor in COMPARE; every other state counts down by one.
  assign sub_b_d = (state_q == ST_COMPARE) ? price_q : 4'd1;

  parallel_subtractor u_sub (
    .a_i    (credit_q),
    .b_i    (sub_b_d),
    .diff_o (sub_diff_d),
    .bout_o (sub_bout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= 4'd0;
      item_q        <= 2'd0;
      price_q       <= 4'd0;
      tmo_q         <= '0;
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        ST_IDLE, ST_CREDIT: begin
          if (cancel) begin
            coin_reject_q <= coin_valid;
            tmo_q         <= '0;
            if (state_q == ST_CREDIT && credit_q != 4'd0) state_q <= ST_CHANGE;
          end else if (sel_valid) begin
            coin_reject_q <= coin_valid;
            tmo_q         <= '0;
            if (state_q == ST_CREDIT) begin
              item_q  <= sel;
              price_q <= sel_price_d;
              state_q <= ST_COMPARE;
            end else begin
              err_q <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_fits_d) begin
              credit_q <= coin_sum_d[3:0];
              tmo_q    <= '0;
              state_q  <= ST_CREDIT;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end else if (state_q == ST_CREDIT) begin
            if (tmo_q == TMO_LAST) state_q <= ST_CHANGE;
            else                   tmo_q   <= tmo_q + 1'b1;
          end
        end
        ST_COMPARE: begin
          coin_reject_q <= coin_valid;
          if (sub_bout_d) begin
            credit_q <= sub_diff_d;
            state_q  <= ST_DISPENSE;
          end else begin
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= ST_CREDIT;
          end
        end
        ST_DISPENSE: begin
          coin_reject_q <= coin_valid;
          state_q       <= (credit_q != 4'd0) ? ST_CHANGE : ST_IDLE;
        end
        ST_CHANGE: begin
          coin_reject_q <= coin_valid;
          if (credit_q <= 4'd1) begin
            credit_q <= 4'd0;
            state_q  <= ST_IDLE;
          end else begin
            credit_q <= sub_diff_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign credit           = credit_q;
  assign busy             = (state_q == ST_COMPARE) || (state_q == ST_DISPENSE) ||
                            (state_q == ST_CHANGE);
  assign dispense         = (state_q == ST_DISPENSE);
  assign dispense_item    = item_q;
  assign change_pulse     = (state_q == ST_CHANGE);
  assign coin_reject      = coin_reject_q;
  assign err_insufficient = err_q;
  assign state_dbg        = state_q;

endmodule
